modular_inverse: RTL and testbench

Computes the multiplicative inverse of an unsigned value modulo an unsigned modulus using the iterative extended Euclidean algorithm. It is the key-derivation counterpart of the modular-exponentiation datapath: it produces the private exponent d = e⁻¹ mod φ consumed by the exponentiation block. It also flags when no inverse exists. Uses the same ready/busy/valid handshake as the other arithmetic blocks in the key pipeline.

---
 rtl/modular_inverse_pkg.sv | 25 ++
 rtl/modular_inverse_divider.sv | 71 +++++++
 rtl/modular_inverse.sv | 138 +++++++++++++
 tb/tb_modular_inverse.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/modular_inverse_pkg.sv
// Shared key-arithmetic definitions for the modular inverse datapath.
// Holds the FSM state encoding, the signed Bezout coefficient type and latency constants.
package modular_inverse_pkg;

  localparam int unsigned MI_WIDTH    = 8;
  localparam int unsigned COEF_W      = MI_WIDTH + 2;
  // One Euclid step: CHECK + MI_WIDTH divider cycles + UPDATE
  localparam int unsigned ITER_CYCLES = MI_WIDTH + 2;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIVIDE,
    UPDATE,
    FINISH
  } state_t;

  // Accept-to-valid latency for k Euclid iterations
  function automatic int unsigned inverse_latency(input int unsigned k);
    return k * ITER_CYCLES + 2;
  endfunction

endpackage

// File: rtl/modular_inverse_divider.sv
// WIDTH-bit unsigned restoring divider, one quotient bit per cycle.
// The first bit is resolved on the start edge so done pulses WIDTH cycles after start.
module restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] cnt;
  logic             active;

  logic [WIDTH-1:0] src_rem_c;
  logic [WIDTH-1:0] src_quo_c;
  logic [WIDTH-1:0] src_div_c;
  logic [WIDTH:0]   partial_c;
  logic [WIDTH-1:0] next_rem_c;
  logic [WIDTH-1:0] next_quo_c;

  // One restoring step; on start it works directly on the incoming operands
  always_comb begin
    src_rem_c  = start ? '0 : remainder;
    src_quo_c  = start ? dividend : quotient;
    src_div_c  = start ? divisor : div_q;
    partial_c  = {src_rem_c, src_quo_c[WIDTH-1]};
    next_rem_c = partial_c[WIDTH-1:0];
    next_quo_c = {src_quo_c[WIDTH-2:0], 1'b0};
    if (partial_c >= {1'b0, src_div_c}) begin
      next_rem_c = WIDTH'(partial_c - {1'b0, src_div_c});
      next_quo_c = {src_quo_c[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      div_q     <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient  <= next_quo_c;
        remainder <= next_rem_c;
        div_q     <= divisor;
        cnt       <= CNT_W'(WIDTH - 1);
        active    <= 1'b1;
      end else if (active) begin
        quotient  <= next_quo_c;
        remainder <= next_rem_c;
        cnt       <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/modular_inverse.sv
// Modular inverse via iterative extended Euclid with ready/busy/valid handshake.
// Optional MODULAR_INVERSE_GCD_EN adds gcd_out carrying the final remainder gcd(a, m).
module modular_inverse
  import modular_inverse_pkg::*;
#(
  parameter int unsigned WIDTH = MI_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] value_out,
  output logic             exists_out,
  output logic             busy_out,
`ifdef MODULAR_INVERSE_GCD_EN
  output logic [WIDTH-1:0] gcd_out,
  output logic             valid_out
`else
  output logic             valid_out
`endif
);

  localparam int unsigned CW = WIDTH + 2;
  localparam int unsigned PW = 2 * WIDTH + 2;

  state_t state;

  logic [WIDTH-1:0]     r0;
  logic [WIDTH-1:0]     r1;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     q_q;
  logic [WIDTH-1:0]     rem_q;
  logic signed [CW-1:0] t0;
  logic signed [CW-1:0] t1;

  logic signed [PW-1:0] q_ext_c;
  logic signed [PW-1:0] t1_ext_c;
  logic signed [CW-1:0] t_next_c;
  logic                 exists_c;
  logic [WIDTH-1:0]     result_c;
  logic                 div_start_c;

  logic [WIDTH-1:0]     div_quotient;
  logic [WIDTH-1:0]     div_remainder;
  logic                 div_done;

  // |t| never exceeds m, so truncating the product back to CW bits is lossless
  always_comb begin
    q_ext_c     = $signed({{CW{1'b0}}, q_q});
    t1_ext_c    = $signed({{WIDTH{t1[CW-1]}}, t1});
    t_next_c    = t0 - CW'(q_ext_c * t1_ext_c);
    exists_c    = (r0 == WIDTH'(1)) && (m_q >= WIDTH'(2));
    result_c    = '0;
    if (exists_c) begin
      if (t0[CW-1]) result_c = WIDTH'(t0 + $signed({2'b00, m_q}));
      else          result_c = WIDTH'(t0);
    end
    div_start_c = (state == CHECK) && (r1 != '0);
  end

  restoring_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk       (clk_in),
    .rst       (rst_in),
    .start     (div_start_c),
    .dividend  (r0),
    .divisor   (r1),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .done      (div_done)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      r0         <= '0;
      r1         <= '0;
      m_q        <= '0;
      q_q        <= '0;
      rem_q      <= '0;
      t0         <= '0;
      t1         <= '0;
      value_out  <= '0;
      exists_out <= 1'b0;
      busy_out   <= 1'b0;
      valid_out  <= 1'b0;
`ifdef MODULAR_INVERSE_GCD_EN
      gcd_out    <= '0;
`endif
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (ready_in) begin
            m_q      <= modulus_in;
            r0       <= modulus_in;
            r1       <= value_in;
            t0       <= '0;
            t1       <= CW'(1);
            busy_out <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          state <= (r1 == '0) ? FINISH : DIVIDE;
        end
        DIVIDE: begin
          if (div_done) begin
            q_q   <= div_quotient;
            rem_q <= div_remainder;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          r0    <= r1;
          r1    <= rem_q;
          t0    <= t1;
          t1    <= t_next_c;
          state <= CHECK;
        end
        FINISH: begin
          value_out  <= result_c;
          exists_out <= exists_c;
`ifdef MODULAR_INVERSE_GCD_EN
          gcd_out    <= r0;
`endif
          busy_out   <= 1'b0;
          valid_out  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_inverse.sv
// Directed bench for modular_inverse: known inverses, no-inverse cases, busy and reset behaviour.
// Define MODULAR_INVERSE_GCD_EN to also check gcd_out.
module tb_modular_inverse;
  import modular_inverse_pkg::*;

  localparam int unsigned W = MI_WIDTH;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         ready_in;
  logic [W-1:0] value_in;
  logic [W-1:0] modulus_in;
  logic [W-1:0] value_out;
  logic         exists_out;
  logic         busy_out;
  logic         valid_out;
`ifdef MODULAR_INVERSE_GCD_EN
  logic [W-1:0] gcd_out;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcount = 0;
  int t_acc  = 0;

  modular_inverse #(.WIDTH(W)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ready_in   (ready_in),
    .value_in   (value_in),
    .modulus_in (modulus_in),
    .value_out  (value_out),
    .exists_out (exists_out),
    .busy_out   (busy_out),
`ifdef MODULAR_INVERSE_GCD_EN
    .gcd_out    (gcd_out),
`endif
    .valid_out  (valid_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (valid_out) vcount <= vcount + 1;
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one request for a single cycle and note the accept edge
  task automatic start_op(input int unsigned a, input int unsigned m);
    @(negedge clk_in);
    value_in   = W'(a);
    modulus_in = W'(m);
    ready_in   = 1'b1;
    @(posedge clk_in);
    #1;
    t_acc = cyc;
    chk_eq("busy_rise", int'(busy_out), 1);
    @(negedge clk_in);
    ready_in = 1'b0;
  endtask

  // Wait (bounded) for valid_out; busy_out must stay high until then
  task automatic wait_valid(output int lat);
    bit busy_ok = 1'b1;
    bit seen    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_in);
      #1;
      if (valid_out) begin
        seen = 1'b1;
        break;
      end
      if (!busy_out) busy_ok = 1'b0;
    end
    chk_eq("valid_seen", int'(seen), 1);
    chk_eq("busy_hold", int'(busy_ok), 1);
    lat = cyc - t_acc;
  endtask

  task automatic run_op(input string tag, input int unsigned a, input int unsigned m,
                        input int unsigned ev, input int unsigned ee,
                        input int unsigned eg, input int unsigned k);
    int lat;
    start_op(a, m);
    wait_valid(lat);
    chk_eq({tag, "_value"}, int'(value_out), int'(ev));
    chk_eq({tag, "_exists"}, int'(exists_out), int'(ee));
    chk_eq({tag, "_latency"}, lat, int'(inverse_latency(k)));
    chk_eq({tag, "_busy_low"}, int'(busy_out), 0);
`ifdef MODULAR_INVERSE_GCD_EN
    chk_eq({tag, "_gcd"}, int'(gcd_out), int'(eg));
`else
    if (eg == 0) chk_eq({tag, "_gcd_arg"}, int'(eg), 1);
`endif
    @(posedge clk_in);
    #1;
    chk_eq({tag, "_valid_pulse"}, int'(valid_out), 0);
    chk_eq({tag, "_value_hold"}, int'(value_out), int'(ev));
  endtask

  initial begin
    int lat;
    int v0;
    rst_in     = 1'b1;
    ready_in   = 1'b0;
    value_in   = '0;
    modulus_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_eq("rst_value", int'(value_out), 0);
    chk_eq("rst_exists", int'(exists_out), 0);
    chk_eq("rst_busy", int'(busy_out), 0);
    chk_eq("rst_valid", int'(valid_out), 0);
    rst_in = 1'b0;

    //      tag        a    m    inv ex gcd k
    run_op("a3m11",     3,  11,  4, 1, 1, 3);
    run_op("a7m40",     7,  40, 23, 1, 1, 4);
    run_op("a255m254", 255, 254, 1, 1, 1, 3);
    run_op("a1m7",      1,   7,  1, 1, 1, 1);
    // Consecutive Fibonacci operands: 11 Euclid steps
    run_op("a144m233", 144, 233, 89, 1, 1, 11);
    run_op("a6m9",      6,   9,  0, 0, 3, 2);
    run_op("a0m7",      0,   7,  0, 0, 7, 0);
    run_op("a5m1",      5,   1,  0, 0, 1, 2);
    run_op("a5m0",      5,   0,  0, 0, 5, 1);

    // Request while busy must be ignored
    start_op(3, 11);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    value_in   = 8'd2;
    modulus_in = 8'd5;
    ready_in   = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    wait_valid(lat);
    chk_eq("busy_req_value", int'(value_out), 4);
    chk_eq("busy_req_latency", lat, int'(inverse_latency(3)));
    v0 = vcount;
    repeat (30) @(posedge clk_in);
    #1;
    chk_eq("no_second_valid", vcount - v0, 1);

    // Reset mid-run aborts without a result strobe
    start_op(144, 233);
    repeat (20) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk_eq("abort_value", int'(value_out), 0);
    chk_eq("abort_exists", int'(exists_out), 0);
    chk_eq("abort_busy", int'(busy_out), 0);
    chk_eq("abort_valid", int'(valid_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    v0 = vcount;
    repeat (150) @(posedge clk_in);
    #1;
    chk_eq("abort_no_valid", vcount - v0, 0);
    run_op("after_rst", 3, 11, 4, 1, 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
